// File: rtl/sense_amp_capture.sv
// -----------------------------------------------------------------------------
// sense_amp_capture
//
// Consumer of the wired-OR sense-amplifier bus (SAP, SA01..SA14, SA16).
// A rising edge on either read strobe (SBF = fixed memory, SBE = erasable
// memory) starts a capture. The bus is sampled SETTLE_CYC cycles later, odd
// parity is checked, and the word is held for the G-register loader behind a
// valid/ack handshake. Dropped strobes and (optional) hold timeouts raise the
// sticky OVRN flag; parity failures raise the sticky PALARM flag.
//
// Parameters
//   SETTLE_CYC  : cycles from the strobe edge to the sample state, 1..15
//   TIMEOUT_CYC : cycles SA_VALID may wait for SA_ACK before the word is
//                 discarded; 0 disables the timeout
//
// Configuration macro
//   SA_PARITY_CHECK_EN : when defined, SA_PERR and PALARM are driven by the
//                        parity checker; when undefined both are tied low.
//                        SA_PAR is captured either way.
//
// Ports
//   SIM_CLK    in   block clock
//   SIM_RST    in   asynchronous active-low reset
//   SBF, SBE   in   read strobes (levels); rising edge starts a capture
//   SAP        in   sense-amp parity bit
//   SA_BUS     in   {SA16, SA14..SA01}, MSB = SA16
//   SA_ACK     in   consumer accepts the held word
//   CLR_FLAGS  in   one-cycle pulse clearing OVRN and PALARM
//   SA_WORD    out  captured data, same order as SA_BUS
//   SA_PAR     out  captured parity bit
//   SA_SRC     out  0 = SBF capture, 1 = SBE capture
//   SA_VALID   out  word held and available
//   SA_PERR    out  parity error on the held word (qualified by SA_VALID)
//   PALARM     out  sticky parity alarm
//   OVRN       out  sticky overrun / timeout flag
// -----------------------------------------------------------------------------
module sense_amp_capture #(
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        SBF,
    input  logic        SBE,
    input  logic        SAP,
    input  logic [14:0] SA_BUS,
    input  logic        SA_ACK,
    input  logic        CLR_FLAGS,
    output logic [14:0] SA_WORD,
    output logic        SA_PAR,
    output logic        SA_SRC,
    output logic        SA_VALID,
    output logic        SA_PERR,
    output logic        PALARM,
    output logic        OVRN
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Hold counter only has to reach TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t          state;
    logic [3:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic            sbf_q;
    logic            sbe_q;

    logic            rise_f;
    logic            rise_e;
    logic            any_rise;
    logic            ack_done;
    logic            accept;
    logic            timeout_hit;
    logic            perr_now;
    logic            ovrn_set;
    logic            palarm_set;

    always_comb begin
        rise_f      = 1'b0;
        rise_e      = 1'b0;
        any_rise    = 1'b0;
        ack_done    = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        perr_now    = 1'b0;
        ovrn_set    = 1'b0;
        palarm_set  = 1'b0;

        rise_f   = SBF & ~sbf_q;
        rise_e   = SBE & ~sbe_q;
        any_rise = rise_f | rise_e;

        // ACK only counts once the word is actually being presented.
        ack_done = SA_VALID & SA_ACK;

        // A strobe is taken when idle, or when the held word is being
        // accepted on this very edge (back-to-back transfer).
        accept = any_rise & ((state == IDLE) | ack_done);

        if (TIMEOUT_CYC > 0) begin
            timeout_hit = SA_VALID & ~SA_ACK & (int'(tcnt) == TIMEOUT_CYC - 1);
        end

`ifdef SA_PARITY_CHECK_EN
        // Odd parity over all 16 sense lines; an all-zero bus is an error.
        perr_now = ~(^{SAP, SA_BUS});
`else
        perr_now = 1'b0;
`endif

        // Both strobes rising together counts as a drop even though SBF is
        // captured.
        ovrn_set   = (any_rise & ~accept) | (rise_f & rise_e) | timeout_hit;
        palarm_set = (state == SAMPLE) & perr_now;
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            sbf_q    <= 1'b0;
            sbe_q    <= 1'b0;
            SA_WORD  <= '0;
            SA_PAR   <= 1'b0;
            SA_SRC   <= 1'b0;
            SA_VALID <= 1'b0;
            SA_PERR  <= 1'b0;
            PALARM   <= 1'b0;
            OVRN     <= 1'b0;
        end else begin
            sbf_q <= SBF;
            sbe_q <= SBE;

            // Set events take priority over a simultaneous clear.
            OVRN   <= ovrn_set   | (OVRN   & ~CLR_FLAGS);
            PALARM <= palarm_set | (PALARM & ~CLR_FLAGS);

            case (state)
                IDLE: begin
                    if (any_rise) begin
                        SA_SRC <= ~rise_f;
                        cnt    <= 4'(SETTLE_CYC - 1);
                        state  <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    SA_WORD <= SA_BUS;
                    SA_PAR  <= SAP;
                    SA_PERR <= perr_now;
                    tcnt    <= '0;
                    state   <= HOLD;
                end

                HOLD: begin
                    if (!SA_VALID) begin
                        // First HOLD cycle: present the word registered in
                        // SAMPLE.
                        SA_VALID <= 1'b1;
                    end else if (ack_done) begin
                        SA_VALID <= 1'b0;
                        if (any_rise) begin
                            SA_SRC <= ~rise_f;
                            cnt    <= 4'(SETTLE_CYC - 1);
                            state  <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        SA_VALID <= 1'b0;
                        state    <= IDLE;
                    end else if (TIMEOUT_CYC > 0) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sense_amp_capture.sv
// -----------------------------------------------------------------------------
// tb_sense_amp_capture
//
// Drives two instances from the same stimulus: one with no hold timeout and
// one with TIMEOUT_CYC=4. Each is compared every cycle against a timeline
// model: a capture accepted at edge t samples the bus at edge t+SETTLE+1 and
// presents it from edge t+SETTLE+2 until an ACK (or, if enabled, until
// TIMEOUT edges pass with no ACK). Directed scenarios come first, followed by
// a randomized run.
// -----------------------------------------------------------------------------
module tb_sense_amp_capture;

    localparam int SETTLE = 3;
    localparam int TMO    = 4;
`ifdef SA_PARITY_CHECK_EN
    localparam logic PC = 1'b1;
`else
    localparam logic PC = 1'b0;
`endif

    typedef struct {
        bit          ps_f;
        bit          ps_e;
        bit          busy;
        bit          valid;
        int          t_acc;
        int          t_valid;
        logic [14:0] word;
        bit          par;
        bit          src;
        bit          perr;
        bit          palarm;
        bit          ovrn;
    } m_t;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic        SBF, SBE, SAP, SA_ACK, CLR_FLAGS;
    logic [14:0] SA_BUS;

    logic [14:0] w0, w1;
    logic        p0, s0, v0, pe0, pa0, ov0;
    logic        p1, s1, v1, pe1, pa1, ov1;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    string phase  = "init";
    m_t    mm, mt;

    always #5 SIM_CLK = ~SIM_CLK;

    sense_amp_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(0)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .SBF(SBF), .SBE(SBE), .SAP(SAP),
        .SA_BUS(SA_BUS), .SA_ACK(SA_ACK), .CLR_FLAGS(CLR_FLAGS),
        .SA_WORD(w0), .SA_PAR(p0), .SA_SRC(s0), .SA_VALID(v0),
        .SA_PERR(pe0), .PALARM(pa0), .OVRN(ov0)
    );

    sense_amp_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut_to (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .SBF(SBF), .SBE(SBE), .SAP(SAP),
        .SA_BUS(SA_BUS), .SA_ACK(SA_ACK), .CLR_FLAGS(CLR_FLAGS),
        .SA_WORD(w1), .SA_PAR(p1), .SA_SRC(s1), .SA_VALID(v1),
        .SA_PERR(pe1), .PALARM(pa1), .OVRN(ov1)
    );

    function automatic m_t m_zero();
        m_t z;
        z = '{default: '0};
        return z;
    endfunction

    // One clock edge of the reference timeline; inputs are the values seen
    // at that edge.
    function automatic m_t step(m_t m, int tmo, int c, bit sbf, bit sbe,
                                bit sap, logic [14:0] bus, bit ack, bit clr);
        bit rf, re, ack_done, to, acc, set_ov, set_pa;
        rf       = sbf && !m.ps_f;
        re       = sbe && !m.ps_e;
        ack_done = m.valid && ack;
        to       = (tmo > 0) && m.valid && !ack && (c == m.t_valid + tmo);
        acc      = (rf || re) && (!m.busy || ack_done);
        set_ov   = ((rf || re) && !acc) || (rf && re) || to;
        set_pa   = 1'b0;
        if (m.busy && !m.valid && c == m.t_acc + SETTLE + 1) begin
            m.word = bus;
            m.par  = sap;
            m.perr = PC && (($countones({sap, bus}) % 2) == 0);
            set_pa = m.perr;
        end
        if (m.busy && !m.valid && c == m.t_acc + SETTLE + 2) begin
            m.valid   = 1'b1;
            m.t_valid = c;
        end
        if (ack_done || to) begin
            m.valid = 1'b0;
            m.busy  = 1'b0;
        end
        if (acc) begin
            m.busy  = 1'b1;
            m.t_acc = c;
            m.src   = !rf;
        end
        m.ovrn   = set_ov || (m.ovrn && !clr);
        m.palarm = set_pa || (m.palarm && !clr);
        m.ps_f   = sbf;
        m.ps_e   = sbe;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s [%s] cyc=%0d got=%h exp=%h", tag, phase, cyc, got, exp);
        end
    endtask

    task automatic chk_dut(input string who, input m_t e, input logic [14:0] w,
                           input logic p, input logic s, input logic v,
                           input logic pe, input logic pa, input logic ov);
        chk({who, ".word"},   {1'b0, w},   {1'b0, e.word});
        chk({who, ".par"},    {15'b0, p},  {15'b0, e.par});
        chk({who, ".src"},    {15'b0, s},  {15'b0, e.src});
        chk({who, ".valid"},  {15'b0, v},  {15'b0, e.valid});
        chk({who, ".perr"},   {15'b0, pe}, {15'b0, e.perr});
        chk({who, ".palarm"}, {15'b0, pa}, {15'b0, e.palarm});
        chk({who, ".ovrn"},   {15'b0, ov}, {15'b0, e.ovrn});
    endtask

    task automatic check_all();
        chk_dut("main", mm, w0, p0, s0, v0, pe0, pa0, ov0);
        chk_dut("tmo",  mt, w1, p1, s1, v1, pe1, pa1, ov1);
    endtask

    // Advance one clock: update the models at the edge, compare at negedge.
    task automatic tick();
        @(posedge SIM_CLK);
        cyc++;
        if (!SIM_RST) begin
            mm = m_zero();
            mt = m_zero();
        end else begin
            mm = step(mm, 0,   cyc, SBF, SBE, SAP, SA_BUS, SA_ACK, CLR_FLAGS);
            mt = step(mt, TMO, cyc, SBF, SBE, SAP, SA_BUS, SA_ACK, CLR_FLAGS);
        end
        @(negedge SIM_CLK);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        SIM_RST = 1'b0; SBF = 1'b0; SBE = 1'b0; SAP = 1'b0;
        SA_BUS = '0; SA_ACK = 1'b0; CLR_FLAGS = 1'b0;
        mm = m_zero();
        mt = m_zero();

        // Reset state
        phase = "reset";
        ticks(3);
        chk("rst.valid", {15'b0, v0}, 16'd0);
        chk("rst.word",  {1'b0, w0},  16'd0);
        SIM_RST = 1'b1;
        ticks(2);

        // Parity OK and latency: valid exactly at strobe edge + 5
        phase = "latency";
        SA_BUS = 15'h0001; SAP = 1'b0; SA_ACK = 1'b1;
        SBF = 1'b1; tick();
        SBF = 1'b0; ticks(4);
        chk("lat.valid_e4", {15'b0, v0}, 16'd0);
        tick();
        chk("lat.valid_e5", {15'b0, v0},  16'd1);
        chk("lat.word",     {1'b0, w0},   16'h0001);
        chk("lat.src",      {15'b0, s0},  16'd0);
        chk("lat.perr",     {15'b0, pe0}, 16'd0);
        ticks(2);

        // Parity error from SBE (three data ones plus SAP = even count)
        phase = "parity";
        SA_ACK = 1'b0; SA_BUS = 15'h0007; SAP = 1'b1;
        SBE = 1'b1; tick();
        SBE = 1'b0; ticks(5);
        chk("par.valid",  {15'b0, v0},  16'd1);
        chk("par.src",    {15'b0, s0},  16'd1);
        chk("par.sap",    {15'b0, p0},  16'd1);
        chk("par.perr",   {15'b0, pe0}, {15'b0, PC});
        chk("par.palarm", {15'b0, pa0}, {15'b0, PC});
        SA_ACK = 1'b1; tick();
        SA_ACK = 1'b0; ticks(3);
        chk("par.palarm_sticky", {15'b0, pa0}, {15'b0, PC});
        CLR_FLAGS = 1'b1; tick();
        CLR_FLAGS = 1'b0;
        chk("par.palarm_clr", {15'b0, pa0}, 16'd0);
        tick();

        // Overrun: second strobe in SETTLE, third in HOLD without ACK
        phase = "overrun";
        SA_BUS = 15'h1234; SAP = 1'b1;
        SBF = 1'b1; tick();
        SBF = 1'b0; tick();
        SBF = 1'b1; tick();
        SBF = 1'b0; ticks(3);
        SA_BUS = 15'h0F0F; tick();
        SBF = 1'b1; tick();
        SBF = 1'b0; tick();
        chk("ovr.word",  {1'b0, w0},  16'h1234);
        chk("ovr.valid", {15'b0, v0}, 16'd1);
        chk("ovr.ovrn",  {15'b0, ov0}, 16'd1);
        SA_ACK = 1'b1; tick();
        SA_ACK = 1'b0; CLR_FLAGS = 1'b1; tick();
        CLR_FLAGS = 1'b0; ticks(2);

        // Back-to-back: ACK and a new SBE rise on the same edge
        phase = "b2b";
        SA_BUS = 15'h2AAA; SAP = 1'b0;
        SBF = 1'b1; tick();
        SBF = 1'b0; ticks(6);
        SA_ACK = 1'b1; SBE = 1'b1; tick();
        chk("b2b.valid_low", {15'b0, v0}, 16'd0);
        SA_ACK = 1'b0; SBE = 1'b0; SA_BUS = 15'h5555; SAP = 1'b1;
        ticks(4);
        chk("b2b.valid_e4", {15'b0, v0}, 16'd0);
        tick();
        chk("b2b.valid_e5", {15'b0, v0}, 16'd1);
        chk("b2b.word",     {1'b0, w0},  16'h5555);
        chk("b2b.src",      {15'b0, s0}, 16'd1);
        chk("b2b.ovrn",     {15'b0, ov0}, 16'd0);
        SA_ACK = 1'b1; tick();
        SA_ACK = 1'b0; ticks(2);

        // Simultaneous SBF/SBE rise: SBF wins, overrun flagged
        phase = "both";
        SA_BUS = 15'h0100; SAP = 1'b0; SA_ACK = 1'b1;
        SBF = 1'b1; SBE = 1'b1; tick();
        SBF = 1'b0; SBE = 1'b0; ticks(5);
        chk("both.valid", {15'b0, v0},  16'd1);
        chk("both.src",   {15'b0, s0},  16'd0);
        chk("both.ovrn",  {15'b0, ov0}, 16'd1);
        tick();
        SA_ACK = 1'b0; CLR_FLAGS = 1'b1; tick();
        CLR_FLAGS = 1'b0; tick();

        // Timeout on the TIMEOUT_CYC=4 instance: valid for 4 cycles, then drop
        phase = "timeout";
        SA_BUS = 15'h7001; SAP = 1'b1;
        SBF = 1'b1; tick();
        SBF = 1'b0; ticks(8);
        chk("to.valid_e8", {15'b0, v1}, 16'd1);
        tick();
        chk("to.valid_e9", {15'b0, v1},  16'd0);
        chk("to.ovrn",     {15'b0, ov1}, 16'd1);
        chk("to.main_hold", {15'b0, v0}, 16'd1);
        SA_ACK = 1'b1; tick();
        SA_ACK = 1'b0; CLR_FLAGS = 1'b1; tick();
        CLR_FLAGS = 1'b0; tick();

        // Asynchronous reset during SETTLE
        phase = "midreset";
        SA_BUS = 15'h3333; SAP = 1'b1;
        SBF = 1'b1; tick();
        SBF = 1'b0; tick();
        SIM_RST = 1'b0;
        #1;
        mm = m_zero();
        mt = m_zero();
        check_all();
        chk("mrst.word", {1'b0, w0}, 16'd0);
        tick();
        SIM_RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mrst.no_valid", {15'b0, v0}, 16'd0);
        end

        // Randomized traffic
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            SBF       = ($urandom_range(0, 5) == 0);
            SBE       = ($urandom_range(0, 7) == 0);
            SAP       = 1'($urandom_range(0, 1));
            SA_BUS    = 15'($urandom);
            SA_ACK    = ($urandom_range(0, 2) != 0);
            CLR_FLAGS = ($urandom_range(0, 15) == 0);
            tick();
        end
        SBF = 1'b0; SBE = 1'b0; SA_ACK = 1'b1; CLR_FLAGS = 1'b0;
        ticks(10);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
